// File: rtl/pc_pkg.sv
// Shared types for the next-PC generator: address width, mux select and hold-FSM state encodings.
package pc_pkg;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned RAS_DEPTH = 4;
  localparam int unsigned RAS_PTR_W = 2;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_RET,
    SEL_CALL,
    SEL_JMP
  } sel_e;

  typedef enum logic {
    ST_IDLE,
    ST_HELD
  } state_e;

  function automatic addr_t seq_addr(addr_t pc);
    return pc + addr_t'(1);
  endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Request/response bundle between the fetch/branch logic and pc_next_unit.
interface pc_next_unit_if;

  pc_pkg::addr_t pc_in;
  logic          stall;
  logic          br_taken;
  pc_pkg::addr_t br_target;
  logic          jmp;
  logic          call;
  logic          ret;
  pc_pkg::addr_t jc_target;
  pc_pkg::addr_t next_pc;
  logic          redirect;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_ovf;
  logic          ras_unf;

  modport master (
    output pc_in, stall, br_taken, br_target, jmp, call, ret, jc_target,
    input  next_pc, redirect, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  pc_in, stall, br_taken, br_target, jmp, call, ret, jc_target,
    output next_pc, redirect, ras_empty, ras_full, ras_ovf, ras_unf
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module ras_stack
  import pc_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RAS_PTR_W = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  addr_t push_addr,
  output addr_t top,
  output logic  empty,
  output logic  full,
  output logic  ovf,
  output logic  unf
);

  localparam int unsigned CntW = RAS_PTR_W + 1;
  localparam logic [CntW-1:0] DepthCnt = RAS_DEPTH[CntW-1:0];

  addr_t                mem_q [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] top_q;
  logic [RAS_PTR_W-1:0] top_inc;
  logic [RAS_PTR_W-1:0] top_dec;
  logic [CntW-1:0]      cnt_q;
  logic                 ovf_q;
  logic                 unf_q;

  assign top_inc = top_q + RAS_PTR_W'(1);
  assign top_dec = top_q - RAS_PTR_W'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DepthCnt);
  assign top     = mem_q[top_q];
  assign ovf     = ovf_q;
  assign unf     = unf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) mem_q[i] <= '0;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (push) begin
      mem_q[top_inc] <= push_addr;
      top_q          <= top_inc;
      if (full) ovf_q <= 1'b1;
      else      cnt_q <= cnt_q + CntW'(1);
    end else if (pop) begin
      if (empty) begin
        unf_q <= 1'b1;
      end else begin
        top_q <= top_dec;
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC priority mux plus stall-hold FSM for branch redirects.
// Return-address stack is built only when PC_NEXT_RAS_EN is defined.
module pc_next_unit
  import pc_pkg::*;
(
  input logic           clk,
  input logic           rst,
  pc_next_unit_if.slave bus
);

  state_e state_q, state_d;
  addr_t  hold_q, hold_d;
  sel_e   sel;
  addr_t  seq;
  addr_t  ras_top;
  logic   ras_empty_w;
  logic   ret_req;

  assign seq = seq_addr(bus.pc_in);

`ifdef PC_NEXT_RAS_EN
  logic accept;
  logic push;
  logic pop;

  // Branch squashes fetch-stage requests; ret beats call in the same cycle.
  assign accept  = (state_q == ST_IDLE) && !bus.stall && !bus.br_taken;
  assign pop     = accept && bus.ret;
  assign push    = accept && bus.call && !bus.ret;
  assign ret_req = bus.ret;

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .RAS_PTR_W (RAS_PTR_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (seq),
    .top       (ras_top),
    .empty     (ras_empty_w),
    .full      (bus.ras_full),
    .ovf       (bus.ras_ovf),
    .unf       (bus.ras_unf)
  );
`else
  assign ret_req      = 1'b0;
  assign ras_top      = '0;
  assign ras_empty_w  = 1'b1;
  assign bus.ras_full = 1'b0;
  assign bus.ras_ovf  = 1'b0;
  assign bus.ras_unf  = 1'b0;
`endif

  assign bus.ras_empty = ras_empty_w;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    sel          = SEL_SEQ;
    bus.next_pc  = seq;
    bus.redirect = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.br_taken)  sel = SEL_BR;
        else if (ret_req)  sel = ras_empty_w ? SEL_SEQ : SEL_RET;
        else if (bus.call) sel = SEL_CALL;
        else if (bus.jmp)  sel = SEL_JMP;
        unique case (sel)
          SEL_BR:   bus.next_pc = bus.br_target;
          SEL_RET:  bus.next_pc = ras_top;
          SEL_CALL: bus.next_pc = bus.jc_target;
          SEL_JMP:  bus.next_pc = bus.jc_target;
          default:  bus.next_pc = seq;
        endcase
        bus.redirect = (sel != SEL_SEQ);
        // Stalled PC ignores this cycle's target, so park it until the stall drops.
        if (bus.br_taken && bus.stall) begin
          hold_d  = bus.br_target;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        bus.next_pc  = hold_q;
        bus.redirect = 1'b1;
        if (bus.stall) begin
          if (bus.br_taken) hold_d = bus.br_target;
        end else begin
          if (bus.br_taken) bus.next_pc = bus.br_target;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios plus randomized traffic vs a queue model.
module tb_pc_next_unit;
  import pc_pkg::*;

`ifdef PC_NEXT_RAS_EN
  localparam bit RasEn = 1'b1;
`else
  localparam bit RasEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_next_unit_if bus ();

  pc_next_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: pending-redirect flag and a plain queue of return addresses.
  bit m_held;
  int m_hold;
  int m_ras[$];
  bit m_ovf;
  bit m_unf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int inc(input int pc);
    return (pc + 1) % 4096;
  endfunction

  task automatic model_clear();
    m_held = 1'b0;
    m_hold = 0;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic check_all();
    int  pc;
    int  e;
    bit  red;
    bit  r_eff;
    pc    = int'(bus.pc_in);
    r_eff = RasEn && bus.ret;
    if (m_held) begin
      e   = (!bus.stall && bus.br_taken) ? int'(bus.br_target) : m_hold;
      red = 1'b1;
    end else if (bus.br_taken) begin
      e   = int'(bus.br_target);
      red = 1'b1;
    end else if (r_eff) begin
      red = (m_ras.size() > 0);
      e   = red ? m_ras[$] : inc(pc);
    end else if (bus.call || bus.jmp) begin
      e   = int'(bus.jc_target);
      red = 1'b1;
    end else begin
      e   = inc(pc);
      red = 1'b0;
    end
    check_eq("next_pc", 32'(bus.next_pc), 32'(e));
    check_eq("redirect", 32'(bus.redirect), 32'(red));
    check_eq("ras_empty", 32'(bus.ras_empty), 32'(!RasEn || m_ras.size() == 0));
    check_eq("ras_full", 32'(bus.ras_full), 32'(RasEn && m_ras.size() == int'(RAS_DEPTH)));
    check_eq("ras_ovf", 32'(bus.ras_ovf), 32'(m_ovf));
    check_eq("ras_unf", 32'(bus.ras_unf), 32'(m_unf));
  endtask

  task automatic drive(input int pc, input bit st, input bit br, input int brt,
                       input bit j, input bit c, input bit r, input int jct);
    @(negedge clk);
    bus.pc_in     = pc[ADDR_W-1:0];
    bus.stall     = st;
    bus.br_taken  = br;
    bus.br_target = brt[ADDR_W-1:0];
    bus.jmp       = j;
    bus.call      = c;
    bus.ret       = r;
    bus.jc_target = jct[ADDR_W-1:0];
    #1;
    check_all();
  endtask

  // Advance the model with the currently driven inputs, then let the DUT take the edge.
  task automatic tick();
    if (m_held) begin
      if (bus.stall) begin
        if (bus.br_taken) m_hold = int'(bus.br_target);
      end else begin
        m_held = 1'b0;
      end
    end else if (bus.br_taken) begin
      if (bus.stall) begin
        m_held = 1'b1;
        m_hold = int'(bus.br_target);
      end
    end else if (!bus.stall && RasEn) begin
      if (bus.ret) begin
        if (m_ras.size() > 0) void'(m_ras.pop_back());
        else m_unf = 1'b1;
      end else if (bus.call) begin
        m_ras.push_back(inc(int'(bus.pc_in)));
        if (m_ras.size() > int'(RAS_DEPTH)) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.pc_in = '0; bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0;
    bus.jmp = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.jc_target = '0;
    rst = 1'b0;
    #2;
    do_reset();

    // Sequential path and wrap.
    drive(12'h03F, 0, 0, 0, 0, 0, 0, 0);
    check_eq("seq_03f", 32'(bus.next_pc), 32'h040);
    check_eq("seq_redirect", 32'(bus.redirect), 32'h0);
    tick();
    drive(12'hFFF, 0, 0, 0, 0, 0, 0, 0);
    check_eq("seq_wrap", 32'(bus.next_pc), 32'h000);
    tick();

    // Branch during stall is held until the stall drops.
    drive(12'h020, 1, 1, 12'h07F, 0, 0, 0, 0);
    tick();
    drive(12'h020, 1, 0, 0, 1, 0, 0, 12'h333);
    check_eq("held_addr", 32'(bus.next_pc), 32'h07F);
    tick();
    drive(12'h020, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(12'h020, 0, 0, 0, 0, 0, 0, 0);
    check_eq("held_release", 32'(bus.next_pc), 32'h07F);
    tick();
    drive(12'h07F, 0, 0, 0, 0, 0, 0, 0);
    check_eq("idle_after_hold", 32'(bus.next_pc), 32'h080);
    tick();

    // Newer branch overwrites the held one; release with a branch takes it directly.
    drive(12'h010, 1, 1, 12'h111, 0, 0, 0, 0);
    tick();
    drive(12'h010, 1, 1, 12'h222, 0, 0, 0, 0);
    tick();
    drive(12'h010, 1, 0, 0, 0, 0, 0, 0);
    check_eq("held_overwrite", 32'(bus.next_pc), 32'h222);
    tick();
    drive(12'h010, 0, 1, 12'h444, 0, 0, 0, 0);
    check_eq("held_release_br", 32'(bus.next_pc), 32'h444);
    tick();

`ifdef PC_NEXT_RAS_EN
    drive(12'h010, 0, 0, 0, 0, 1, 0, 12'h200);
    check_eq("call_target", 32'(bus.next_pc), 32'h200);
    tick();
    drive(12'h205, 0, 0, 0, 0, 0, 1, 0);
    check_eq("ret_target", 32'(bus.next_pc), 32'h011);
    tick();
    drive(12'h012, 0, 0, 0, 0, 0, 0, 0);
    check_eq("ret_empty_after", 32'(bus.ras_empty), 32'h1);
    tick();
    for (int i = 1; i <= 5; i++) begin
      drive(i, 0, 0, 0, 0, 1, 0, 12'h300);
      tick();
    end
    drive(12'h050, 0, 0, 0, 0, 0, 0, 0);
    check_eq("ovf_full", 32'(bus.ras_full), 32'h1);
    check_eq("ovf_flag", 32'(bus.ras_ovf), 32'h1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(12'h500, 0, 0, 0, 0, 0, 1, 0);
      check_eq("ret_order", 32'(bus.next_pc), 32'(6 - i));
      tick();
    end
    drive(12'h500, 0, 0, 0, 0, 0, 1, 0);
    check_eq("unf_seq", 32'(bus.next_pc), 32'h501);
    tick();
    drive(12'h500, 0, 0, 0, 0, 0, 0, 0);
    check_eq("unf_flag", 32'(bus.ras_unf), 32'h1);
    tick();
    // Branch squashes a call; ret beats call.
    drive(12'h040, 0, 1, 12'h100, 0, 1, 0, 12'h300);
    check_eq("br_squash", 32'(bus.next_pc), 32'h100);
    tick();
    drive(12'h040, 0, 0, 0, 0, 1, 0, 12'h300);
    tick();
    drive(12'h060, 0, 0, 0, 0, 1, 1, 12'h300);
    check_eq("ret_beats_call", 32'(bus.next_pc), 32'h041);
    tick();
`else
    drive(12'h040, 0, 0, 0, 0, 1, 0, 12'h300);
    check_eq("call_as_jmp", 32'(bus.next_pc), 32'h300);
    tick();
    drive(12'h040, 0, 0, 0, 0, 0, 1, 0);
    check_eq("ret_ignored", 32'(bus.next_pc), 32'h041);
    tick();
`endif

    // Reset while holding a redirect discards it.
    drive(12'h070, 1, 1, 12'h123, 0, 0, 0, 0);
    tick();
    drive(12'h070, 1, 0, 0, 0, 0, 0, 0);
    check_eq("held_before_rst", 32'(bus.redirect), 32'h1);
    rst = 1'b1;
    model_clear();
    #1;
    check_eq("rst_mid_held", 32'(bus.next_pc), 32'h071);
    check_eq("rst_flags", 32'({bus.ras_ovf, bus.ras_unf}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 4095), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
            $urandom_range(0, 4095), ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) < 3), $urandom_range(0, 4095));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Next-address generator directly upstream of the program-counter register; drives that register's 12-bit load input every cycle.
- Selects among a taken-branch redirect, return, call, jump and the sequential address.
- Keeps a small return-address stack (RAS).
- Holds a branch redirect that arrives while the PC is stalled, so the redirect is not lost.

Parameters:
- ADDR_W, 12, instruction address width.
- RAS_DEPTH, 4, return-address stack entries.
- RAS_PTR_W, 2, log2(RAS_DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_in  in  ADDR_W  current PC register output.
- stall  in  1  same stall signal that freezes the PC register.
- br_taken  in  1  branch resolved taken (later pipeline stage).
- br_target  in  ADDR_W  branch target.
- jmp  in  1  unconditional jump (fetch stage).
- call  in  1  call: jump, and push return address.
- ret  in  1  return: pop target from RAS.
- jc_target  in  ADDR_W  jump/call target.
- next_pc  out  ADDR_W  address for the PC register to load.
- redirect  out  1  next_pc is not pc_in+1.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- ras_ovf  out  1  sticky: push while full.
- ras_unf  out  1  sticky: pop while empty.

Behaviour:
- Reset (async) sets the following, released synchronously by design:
  - state=IDLE, hold_addr=0, RAS count=0, top pointer=0, ras_ovf=ras_unf=0.
  - Combinational outputs after reset: next_pc = pc_in+1, redirect=0, ras_empty=1, ras_full=0.
- Sequential address: pc_in+1, modulo 2^ADDR_W (0xFFF -> 0x000).
- Combinational next_pc in IDLE, priority high to low:
  1. br_taken -> br_target.
  2. ret -> RAS top; if RAS empty, pc_in+1.
  3. call -> jc_target.
  4. jmp -> jc_target.
  5. otherwise pc_in+1.
- jmp, call and ret are only consumed when stall=0. Upstream holds them stable while stalled; the block makes no RAS change during stall.
- br_taken squashes same-cycle jmp/call/ret: no push, no pop, no flags set.
- call+ret in the same cycle: ret wins; the call is dropped (no push).
- State machine IDLE/HELD:
  - IDLE, br_taken & stall: hold_addr <= br_target, go to HELD. next_pc = br_target that cycle (ignored by the stalled PC).
  - HELD: next_pc = hold_addr, redirect=1; jmp/call/ret ignored.
  - HELD, br_taken: hold_addr <= br_target; the newer branch overwrites.
  - HELD & ~stall: PC loads hold_addr on this edge; go to IDLE.
  - HELD & ~stall & br_taken: next_pc = br_target; go to IDLE.
- RAS push (call accepted, stall=0): store pc_in+1 at top+1; count = min(count+1, RAS_DEPTH).
  - Push while full: oldest entry overwritten (circular), count stays at RAS_DEPTH, ras_ovf <= 1.
- RAS pop (ret accepted, stall=0): if count>0, count-1 and top-1.
  - Pop while empty: count stays 0, ras_unf <= 1, next_pc = pc_in+1.
- ras_ovf and ras_unf clear only on rst.
- Latency: next_pc is combinational, zero cycles. All state updates occur on the rising clk edge.
- Reset mid-HELD: the pending redirect is discarded.

Optional Feature:
- Macro PC_NEXT_RAS_EN.
- Defined: full RAS as described.
- Undefined:
  - No stack storage.
  - call behaves exactly as jmp.
  - ret is ignored (next_pc = pc_in+1 unless br_taken).
  - ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0 constant.

Decomposition:
- Shared package pc_pkg holds:
  - ADDR_W.
  - Select encoding enum: SEL_SEQ, SEL_BR, SEL_RET, SEL_CALL, SEL_JMP.
  - State enum: ST_IDLE, ST_HELD.
- Sub-module ras_stack: circular stack with push/pop/top/count/full/empty/ovf/unf, parameterised by RAS_DEPTH.
- pc_next_unit owns the priority mux and the hold FSM.

Test Plan:
1. Reset, then pc_in=0x03F with no requests -> next_pc=0x040, redirect=0. pc_in=0xFFF -> next_pc=0x000.
2. call, jc_target=0x200, pc_in=0x010, stall=0 -> next_pc=0x200. Next cycle ret, pc_in=0x205 -> next_pc=0x011, ras_empty=1.
3. stall=1 with br_taken, br_target=0x07F -> HELD. stall held 2 more cycles -> next_pc=0x07F. stall=0 -> PC loads 0x07F, state IDLE next cycle.
4. Five calls with pc_in=0x001..0x005 -> ras_full=1, ras_ovf=1. Then four rets -> 0x006, 0x005, 0x004, 0x003 (0x002 lost). Fifth ret -> ras_unf=1, next_pc=pc_in+1.
5. br_taken(0x100) together with call(0x300), stall=0 -> next_pc=0x100, RAS count unchanged. ret+call together -> ret target, no push.
6. rst asserted while HELD -> next_pc=pc_in+1 immediately, flags cleared. With PC_NEXT_RAS_EN undefined: call(0x300) -> 0x300, ret -> pc_in+1.
